nn_frame_sequencer: RTL and testbench
=====================================

NN_FRAME_SEQUENCER -- requirements
Module: nn_frame_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 1280, active pixels per line.
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch and sync widths in clocks.
- V_ACTIVE, 720, active lines per frame.
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch and sync widths in lines.
REQ-002 clk  in  1  single clock; all logic rises on posedge clk.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin streaming frames.
REQ-005 stop  in  1  one-cycle request to halt after the current frame completes.
REQ-006 enable_cfg  in  3  requested mode for the NN datapath.
REQ-007 pix_valid  in  1  source pixel available.
REQ-008 pix_data  in  24  source pixel, {r[23:16], g[15:8], b[7:0]}.
REQ-009 pix_ready  out  1  sequencer consumes pix_data this cycle.
REQ-010 vs_out, hs_out, de_out  out  1 each  active-high raster timing to nn_rgb.
REQ-011 r_out, g_out, b_out  out  8 each  pixel to nn_rgb.
REQ-012 enable_out  out  3  mode applied to nn_rgb; constant within a frame.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 frame_done  out  1  one-cycle pulse on the last cycle of each frame.
REQ-015 underflow  out  1  sticky; set on any starved active pixel.
REQ-016 frame_cnt  out  16  number of completed frames, wraps 0xFFFF->0.

Function
REQ-017 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-018 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment when h_cnt wraps and SHALL itself wrap at V_TOTAL.
REQ-019 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync SHALL be h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync SHALL be v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), covering whole lines.
REQ-020 FSM states SHALL be IDLE, RUN and STOPPING.
- IDLE->RUN on start, with counters cleared to 0.
- RUN->STOPPING on stop.
- STOPPING->IDLE on the last cycle of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
- start in RUN or STOPPING SHALL be ignored.
- stop in IDLE SHALL be ignored.
- stop and start in the same IDLE cycle: start wins; stop is ignored.
REQ-021 pix_ready SHALL be combinational and high only in RUN or STOPPING while in the active region, regardless of pix_valid.
REQ-022 All timing and pixel outputs SHALL be registered, with a latency of 1 cycle from the counter state to vs/hs/de/rgb.
REQ-023 In an active cycle with pix_valid=1, pix_data SHALL appear on r/g/b the next cycle with de_out=1.
REQ-024 In an active cycle with pix_valid=0, the sequencer SHALL output r/g/b=0 and de_out=1, set underflow, and not stall the raster.
REQ-025 r/g/b SHALL be 0 whenever de_out=0.
REQ-026 In IDLE, all raster outputs SHALL be 0 and the counters SHALL hold at 0.
REQ-027 enable_cfg SHALL be sampled into enable_out only on the cycle entering RUN and on each frame_done while remaining in RUN.
REQ-028 frame_done SHALL pulse on the last cycle of every frame in RUN or STOPPING, and frame_cnt SHALL increment on that same cycle.
REQ-029 underflow SHALL clear only on reset or on IDLE->RUN.

Reset
REQ-030 On reset_n=0 at a posedge: state=IDLE, counters=0, all outputs=0, frame_cnt=0, underflow=0.
REQ-031 Reset mid-frame SHALL abort the frame immediately; no frame_done SHALL be produced.

Structure
REQ-032 The package nn_video_pkg SHALL hold the state enum, the rgb24 struct, and the 720p default timing constants.
REQ-033 A sub-module nn_raster_counter SHALL own the h/v counters, the active/sync decode and the last-cycle flag; the FSM and the output registers SHALL live in the top.

Verification (bench parameters H 8/2/2/2, V 4/1/1/1, so H_TOTAL=14 and V_TOTAL=7)
REQ-034 start with pix_valid held at 1 and an incrementing pattern -> 32 de_out cycles per frame, pixels in order, hs_out 2 cycles wide at h=10..11, vs_out high for all of line 5.
REQ-035 Drop pix_valid for 3 active cycles -> r/g/b=0 on exactly those 3 outputs, de_out remains 1, underflow=1, raster timing unchanged.
REQ-036 stop mid-frame 1 -> frame completes, frame_done pulses, frame_cnt=1, busy falls the cycle after, outputs become 0.
REQ-037 enable_cfg changed from 3'b001 to 3'b100 mid-frame -> enable_out changes only after frame_done.
REQ-038 reset_n low at h=3, v=2 -> next cycle all outputs 0, state IDLE, no frame_done.
REQ-039 Preload frame_cnt to 0xFFFF and run one frame -> frame_cnt=0x0000; simultaneous start and stop in IDLE -> state RUN.

Source files
------------

// File: rtl/nn_video_pkg.sv
// Shared types and default 720p timing for the NN video frame sequencer.
package nn_video_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

endpackage

// File: rtl/nn_raster_counter.sv
// Horizontal/vertical raster counters with active, sync and last-cycle decode.
module nn_raster_counter
  import nn_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_active,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  // Disabled counters sit at the origin so a fresh enable starts a clean frame.
  always_ff @(posedge clk) begin
    if (!reset_n || !i_en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign o_hsync  = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign o_vsync  = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign o_last   = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/nn_frame_sequencer.sv
// Streams pixels into raster-timed frames for nn_rgb; start/stop control FSM.
module nn_frame_sequencer
  import nn_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  enable_cfg,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic [2:0]  enable_out,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow,
  output logic [15:0] frame_cnt,
  input  logic        frame_cnt_load,
  input  logic [15:0] frame_cnt_init,
  output state_t      state_dbg
);

  // Pixel handshake: a pixel is consumed on every cycle pix_ready is high;
  // pix_valid low on such a cycle is a starved pixel, not a stall.

  state_t      r_state, w_state_nxt;
  logic        w_enter_run, w_busy, w_live;
  logic        w_active, w_hsync, w_vsync, w_last, w_frame_done;
  logic        r_vs, r_hs, r_de, r_underflow;
  rgb24_t      r_pix;
  logic [2:0]  r_enable;
  logic [15:0] r_frame_cnt;

  nn_raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_busy),
    .o_active (w_active),
    .o_hsync  (w_hsync),
    .o_vsync  (w_vsync),
    .o_last   (w_last)
  );

  assign w_busy       = (r_state != IDLE);
  assign w_live       = w_busy && w_active;
  assign w_frame_done = w_busy && w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    case (r_state)
      IDLE:     if (start) begin
                  w_state_nxt = RUN;
                  w_enter_run = 1'b1;
                end
      RUN:      if (stop) w_state_nxt = STOPPING;
      STOPPING: if (w_last) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_vs        <= 1'b0;
      r_hs        <= 1'b0;
      r_de        <= 1'b0;
      r_pix       <= '0;
      r_underflow <= 1'b0;
      r_enable    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vs    <= w_busy && w_vsync;
      r_hs    <= w_busy && w_hsync;
      r_de    <= w_live;
      r_pix   <= (w_live && pix_valid) ? rgb24_t'(pix_data) : '0;
      if (w_enter_run)
        r_underflow <= 1'b0;
      else if (w_live && !pix_valid)
        r_underflow <= 1'b1;
      // Mode only changes at frame boundaries so nn_rgb sees one mode per frame.
      if (w_enter_run || (r_state == RUN && w_frame_done))
        r_enable <= enable_cfg;
      if (w_frame_done)
        r_frame_cnt <= r_frame_cnt + 16'd1;
      else if (frame_cnt_load)
        r_frame_cnt <= frame_cnt_init;
    end
  end

  assign pix_ready  = w_live;
  assign vs_out     = r_vs;
  assign hs_out     = r_hs;
  assign de_out     = r_de;
  assign r_out      = r_pix.r;
  assign g_out      = r_pix.g;
  assign b_out      = r_pix.b;
  assign enable_out = r_enable;
  assign busy       = w_busy;
  assign frame_done = w_frame_done;
  assign underflow  = r_underflow;
  assign frame_cnt  = r_frame_cnt;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Bench for nn_frame_sequencer with a small 14x7 raster and a frame-position model.
module tb_nn_frame_sequencer;
  import nn_video_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [2:0]  enable_cfg = 3'b000;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = 24'd1;
  logic        frame_cnt_load = 1'b0;
  logic [15:0] frame_cnt_init = 16'd0;

  logic        pix_ready, vs_out, hs_out, de_out, busy, frame_done, underflow;
  logic [7:0]  r_out, g_out, b_out;
  logic [2:0]  enable_out;
  logic [15:0] frame_cnt;
  state_t      state_dbg;

  nn_frame_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .enable_cfg(enable_cfg), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .enable_out(enable_out),
    .busy(busy), .frame_done(frame_done), .underflow(underflow),
    .frame_cnt(frame_cnt), .frame_cnt_load(frame_cnt_load),
    .frame_cnt_init(frame_cnt_init), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 run, 2 stopping; m_pos is the position in the frame
  int          m_mode = 0;
  int          m_pos = 0;
  bit          m_started = 1'b0;
  logic        m_de = 1'b0, m_hs = 1'b0, m_vs = 1'b0, m_uf = 1'b0;
  logic [2:0]  m_en = 3'b000;
  logic [15:0] m_fcnt = 16'd0;
  logic [23:0] exp_q[$];

  function automatic bit in_active(input int pos);
    return ((pos % HT) < HA) && ((pos / HT) < VA);
  endfunction

  always @(posedge clk) begin
    bit b, act, last;
    int h, v;
    if (!reset_n) begin
      m_mode = 0; m_pos = 0; m_de = 0; m_hs = 0; m_vs = 0;
      m_uf = 0; m_en = 0; m_fcnt = 0; m_started = 1'b1;
      exp_q.delete();
    end else begin
      b    = (m_mode != 0);
      h    = m_pos % HT;
      v    = m_pos / HT;
      act  = b && in_active(m_pos);
      last = b && (m_pos == FT - 1);
      m_de = act;
      m_hs = b && (h >= HA + HF) && (h < HA + HF + HS);
      m_vs = b && (v == VA + VF);
      if (act) exp_q.push_back(pix_valid ? pix_data : 24'd0);
      if (act && !pix_valid) m_uf = 1'b1;
      if (last) begin
        m_fcnt = m_fcnt + 16'd1;
        if (m_mode == 1) m_en = enable_cfg;
      end else if (frame_cnt_load) begin
        m_fcnt = frame_cnt_init;
      end
      case (m_mode)
        0: if (start) begin m_mode = 1; m_uf = 1'b0; m_en = enable_cfg; end
        1: if (stop) m_mode = 2;
        default: if (last) m_mode = 0;
      endcase
      m_pos = b ? (m_pos + 1) % FT : 0;
    end
  end

  // scoreboard / per-cycle compare
  int cnt_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_zero = 0, cnt_fd = 0;

  always @(posedge clk) begin
    logic [23:0] exp_pix;
    state_t      exp_st;
    #2;
    if (m_started) begin
      exp_st = (m_mode == 0) ? IDLE : (m_mode == 1) ? RUN : STOPPING;
      check("de_out", de_out, m_de);
      check("hs_out", hs_out, m_hs);
      check("vs_out", vs_out, m_vs);
      if (m_de) begin
        if (exp_q.size() == 0) check("rgb_queue", 1, 0);
        else begin
          exp_pix = exp_q.pop_front();
          check("rgb", {r_out, g_out, b_out}, exp_pix);
        end
      end else begin
        check("rgb_blank", {r_out, g_out, b_out}, 0);
      end
      check("pix_ready", pix_ready, (m_mode != 0) && in_active(m_pos));
      check("busy", busy, m_mode != 0);
      check("frame_done", frame_done, (m_mode != 0) && (m_pos == FT - 1));
      check("underflow", underflow, m_uf);
      check("frame_cnt", frame_cnt, m_fcnt);
      check("enable_out", enable_out, m_en);
      check("state", state_dbg, exp_st);
      if (de_out) cnt_de++;
      if (de_out && {r_out, g_out, b_out} == 24'd0) cnt_zero++;
      if (hs_out) cnt_hs++;
      if (vs_out) cnt_vs++;
      if (frame_done) cnt_fd++;
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic step(input int n);
    bit cons;
    for (int i = 0; i < n; i++) begin
      cons = (pix_ready === 1'b1) && pix_valid;
      @(posedge clk);
      @(negedge clk);
      if (cons) pix_data = pix_data + 24'd1;
    end
  endtask

  task automatic clear_counts();
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_zero = 0; cnt_fd = 0;
  endtask

  initial begin
    step(3);
    reset_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_de", de_out, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_underflow", underflow, 0);
    check("rst_state", state_dbg, IDLE);

    // frame 1: continuous valid pixels
    enable_cfg = 3'b001;
    pix_valid  = 1'b1;
    clear_counts();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(FT);
    check("f1_de_count", cnt_de, 32);
    check("f1_hs_count", cnt_hs, 14);
    check("f1_vs_count", cnt_vs, 14);
    check("f1_fd_count", cnt_fd, 1);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_last_pixel", pix_data, 24'd33);

    // frame 2: three starved pixels and a mid-frame mode change
    clear_counts();
    step(16);
    pix_valid = 1'b0;
    step(3);
    pix_valid  = 1'b1;
    enable_cfg = 3'b100;
    step(1);
    check("f2_underflow", underflow, 1);
    check("f2_enable_hold", enable_out, 3'b001);
    step(FT - 20);
    check("f2_enable_new", enable_out, 3'b100);
    check("f2_de_count", cnt_de, 32);
    check("f2_zero_count", cnt_zero, 3);
    check("f2_hs_count", cnt_hs, 14);
    check("f2_frame_cnt", frame_cnt, 2);

    // frame 3: stop mid-frame
    clear_counts();
    step(10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(86);
    check("stop_frame_done", frame_done, 1);
    check("stop_busy_last", busy, 1);
    step(1);
    check("stop_busy_after", busy, 0);
    check("stop_state", state_dbg, IDLE);
    check("stop_frame_cnt", frame_cnt, 3);
    check("stop_fd_count", cnt_fd, 1);
    step(3);
    check("stop_de_idle", de_out, 0);

    // reset at h=3, v=2
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2 * HT + 3);
    clear_counts();
    reset_n = 1'b0;
    step(1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_de", de_out, 0);
    check("mid_rst_rgb", {r_out, g_out, b_out}, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    step(FT + 2);
    check("mid_rst_no_fd", cnt_fd, 0);

    // frame counter wrap, with start and stop together in IDLE
    frame_cnt_load = 1'b1;
    frame_cnt_init = 16'hFFFF;
    step(1);
    frame_cnt_load = 1'b0;
    check("preload", frame_cnt, 16'hFFFF);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("start_wins", state_dbg, RUN);
    step(FT - 1);
    check("wrap_frame_done", frame_done, 1);
    step(1);
    check("wrap_frame_cnt", frame_cnt, 16'h0000);
    check("wrap_still_run", state_dbg, RUN);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(FT + 2);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
